// File: rtl/button_conditioner_pkg.sv
// Shared constants for the push-button input path: board button indices,
// default timing at 100 MHz, repeat FSM encodings and counter sizing.
package button_conditioner_pkg;

    localparam int unsigned MEGA = 1_000_000;

    localparam int unsigned BTN_C = 0;
    localparam int unsigned BTN_U = 1;
    localparam int unsigned BTN_L = 2;
    localparam int unsigned BTN_R = 3;
    localparam int unsigned BTN_D = 4;

    localparam int unsigned DEF_N_BTN                = 5;
    localparam int unsigned DEF_DEBOUNCE_CYCLES      = MEGA;       // 10 ms
    localparam int unsigned DEF_REPEAT_DELAY_CYCLES  = 50 * MEGA;  // 500 ms
    localparam int unsigned DEF_REPEAT_PERIOD_CYCLES = 10 * MEGA;  // 100 ms
    localparam logic [4:0]  DEF_REPEAT_MASK          = 5'b00010;   // BTNU only

    typedef logic [1:0] rpt_state_t;

    localparam rpt_state_t StIdle   = 2'd0;
    localparam rpt_state_t StDelay  = 2'd1;
    localparam rpt_state_t StRepeat = 2'd2;

    // One counter width serves both the debouncer and the repeat timer.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Button pin / conditioned-event bundle between the board pins and mode logic.
interface button_conditioner_if #(
    parameter int unsigned N_BTN = 5
);

    logic [N_BTN-1:0] btn_in;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
    logic [N_BTN-1:0] btn_repeat;

    modport master (
        output btn_in,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  btn_repeat
    );

    modport slave (
        input  btn_in,
        output btn_level,
        output btn_press,
        output btn_release,
        output btn_repeat
    );

endinterface

// File: rtl/button_channel.sv
// One button: 2-FF synchronizer, counter debouncer, press/release pulses and an
// optional hold-to-auto-repeat FSM. All outputs are registered.
module button_channel
    import button_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES      = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY_CYCLES  = DEF_REPEAT_DELAY_CYCLES,
    parameter int unsigned REPEAT_PERIOD_CYCLES = DEF_REPEAT_PERIOD_CYCLES,
    parameter bit          REPEAT_EN            = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic repeat_o
);

    localparam int unsigned CntW =
        cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY_CYCLES, REPEAT_PERIOD_CYCLES);
    localparam logic [CntW-1:0] DbLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic            s1_q, s2_q;
    logic            stable_q, stable_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            press_q, release_q;
    logic            rise, fall;

    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        rise     = 1'b0;
        fall     = 1'b0;
        if (s2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == DbLast) begin
            stable_d = s2_q;
            cnt_d    = '0;
            rise     = s2_q;
            fall     = ~s2_q;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            stable_q  <= 1'b0;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            s1_q      <= btn_i;
            s2_q      <= s1_q;
            stable_q  <= stable_d;
            cnt_q     <= cnt_d;
            press_q   <= rise;
            release_q <= fall;
        end
    end

    assign level_o   = stable_q;
    assign press_o   = press_q;
    assign release_o = release_q;

    generate
        if (REPEAT_EN) begin : g_repeat
            localparam logic [CntW-1:0] RdLast = CntW'(REPEAT_DELAY_CYCLES - 1);
            localparam logic [CntW-1:0] RpLast = CntW'(REPEAT_PERIOD_CYCLES - 1);

            rpt_state_t      state_q, state_d;
            logic [CntW-1:0] rcnt_q, rcnt_d;
            logic            rep_q, rep_d;

            // A release always wins over a simultaneous timer expiry.
            always_comb begin
                state_d = state_q;
                rcnt_d  = rcnt_q;
                rep_d   = 1'b0;
                case (state_q)
                    StIdle: begin
                        if (rise) begin
                            rep_d   = 1'b1;
                            rcnt_d  = '0;
                            state_d = StDelay;
                        end
                    end
                    StDelay: begin
                        if (fall) begin
                            rcnt_d  = '0;
                            state_d = StIdle;
                        end else if (rcnt_q == RdLast) begin
                            rep_d   = 1'b1;
                            rcnt_d  = '0;
                            state_d = StRepeat;
                        end else begin
                            rcnt_d = rcnt_q + CntW'(1);
                        end
                    end
                    StRepeat: begin
                        if (fall) begin
                            rcnt_d  = '0;
                            state_d = StIdle;
                        end else if (rcnt_q == RpLast) begin
                            rep_d  = 1'b1;
                            rcnt_d = '0;
                        end else begin
                            rcnt_d = rcnt_q + CntW'(1);
                        end
                    end
                    default: begin
                        rcnt_d  = '0;
                        state_d = StIdle;
                    end
                endcase
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    state_q <= StIdle;
                    rcnt_q  <= '0;
                    rep_q   <= 1'b0;
                end else begin
                    state_q <= state_d;
                    rcnt_q  <= rcnt_d;
                    rep_q   <= rep_d;
                end
            end

            assign repeat_o = rep_q;
        end else begin : g_no_repeat
            assign repeat_o = 1'b0;
        end
    endgenerate

    a_press_release_exclusive: assert property (
        @(posedge clk) disable iff (reset) !(press_q && release_q)
    );

endmodule

// File: rtl/button_conditioner.sv
// Conditions the board push-buttons into debounced levels and single-cycle
// press/release/repeat events, one independent channel per button.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int unsigned      N_BTN                = DEF_N_BTN,
    parameter int unsigned      DEBOUNCE_CYCLES      = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned      REPEAT_DELAY_CYCLES  = DEF_REPEAT_DELAY_CYCLES,
    parameter int unsigned      REPEAT_PERIOD_CYCLES = DEF_REPEAT_PERIOD_CYCLES,
    parameter logic [N_BTN-1:0] REPEAT_MASK          = 5'b00010
) (
    input logic                 clk,
    input logic                 reset,
    button_conditioner_if.slave btn
);

    logic [N_BTN-1:0] level;
    logic [N_BTN-1:0] press;
    logic [N_BTN-1:0] release_p;
    logic [N_BTN-1:0] repeat_p;

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        button_channel #(
            .DEBOUNCE_CYCLES      (DEBOUNCE_CYCLES),
            .REPEAT_DELAY_CYCLES  (REPEAT_DELAY_CYCLES),
            .REPEAT_PERIOD_CYCLES (REPEAT_PERIOD_CYCLES),
            .REPEAT_EN            (REPEAT_MASK[i])
        ) u_chan (
            .clk       (clk),
            .reset     (reset),
            .btn_i     (btn.btn_in[i]),
            .level_o   (level[i]),
            .press_o   (press[i]),
            .release_o (release_p[i]),
            .repeat_o  (repeat_p[i])
        );
    end

    assign btn.btn_level   = level;
    assign btn.btn_press   = press;
    assign btn.btn_release = release_p;
    assign btn.btn_repeat  = repeat_p;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short debounce/repeat timing.
module tb_button_conditioner;
    import button_conditioner_pkg::*;

    localparam int unsigned NB = 5;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;
    int   press_cnt   [NB];
    int   release_cnt [NB];
    int   repeat_cnt  [NB];
    int   base;

    button_conditioner_if #(.N_BTN(NB)) bus ();

    button_conditioner #(
        .N_BTN                (NB),
        .DEBOUNCE_CYCLES      (4),
        .REPEAT_DELAY_CYCLES  (20),
        .REPEAT_PERIOD_CYCLES (5),
        .REPEAT_MASK          (5'b00010)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .btn   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event counters, sampled mid-cycle.
    always @(negedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (bus.btn_press[b])   press_cnt[b]   <= press_cnt[b] + 1;
            if (bus.btn_release[b]) release_cnt[b] <= release_cnt[b] + 1;
            if (bus.btn_repeat[b])  repeat_cnt[b]  <= repeat_cnt[b] + 1;
        end
    end

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [4:0] lvl, input logic [4:0] prs,
                             input logic [4:0] rel, input logic [4:0] rpt);
        check({tag, ".level"},   32'(bus.btn_level),   32'(lvl));
        check({tag, ".press"},   32'(bus.btn_press),   32'(prs));
        check({tag, ".release"}, 32'(bus.btn_release), 32'(rel));
        check({tag, ".repeat"},  32'(bus.btn_repeat),  32'(rpt));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        for (int b = 0; b < NB; b++) begin
            press_cnt[b]   = 0;
            release_cnt[b] = 0;
            repeat_cnt[b]  = 0;
        end
        reset      = 1'b1;
        bus.btn_in = 5'b11111;

        // Reset with all buttons held, then debounce them in.
        tick(3);
        check_all("rst_hold", 5'b00000, 5'b00000, 5'b00000, 5'b00000);
        reset = 1'b0;
        tick(5);
        check_all("rst_e5", 5'b00000, 5'b00000, 5'b00000, 5'b00000);
        tick(1);
        check_all("rst_e6", 5'b11111, 5'b11111, 5'b00000, 5'b00010);
        tick(1);
        check_all("rst_e7", 5'b11111, 5'b00000, 5'b00000, 5'b00000);
        bus.btn_in = 5'b00000;
        tick(6);
        check_all("rel_all", 5'b00000, 5'b00000, 5'b11111, 5'b00000);
        tick(10);

        // Clean press and release on BTNC.
        bus.btn_in[BTN_C] = 1'b1;
        tick(5);
        check_all("c_e5", 5'b00000, 5'b00000, 5'b00000, 5'b00000);
        tick(1);
        check_all("c_e6", 5'b00001, 5'b00001, 5'b00000, 5'b00000);
        tick(1);
        check_all("c_e7", 5'b00001, 5'b00000, 5'b00000, 5'b00000);
        bus.btn_in[BTN_C] = 1'b0;
        tick(5);
        check_all("c_rel5", 5'b00001, 5'b00000, 5'b00000, 5'b00000);
        tick(1);
        check_all("c_rel6", 5'b00000, 5'b00000, 5'b00001, 5'b00000);
        tick(1);
        check_all("c_rel7", 5'b00000, 5'b00000, 5'b00000, 5'b00000);
        tick(4);

        // Bounce shorter than the debounce window on BTNC.
        base = press_cnt[BTN_C] + release_cnt[BTN_C];
        bus.btn_in[BTN_C] = 1'b1; tick(3);
        bus.btn_in[BTN_C] = 1'b0; tick(1);
        bus.btn_in[BTN_C] = 1'b1; tick(3);
        bus.btn_in[BTN_C] = 1'b0; tick(12);
        check("bounce.level", 32'(bus.btn_level[BTN_C]), 32'd0);
        check("bounce.events", 32'(press_cnt[BTN_C] + release_cnt[BTN_C] - base), 32'd0);

        // Auto-repeat on BTNU; release expires on the same edge as the E+40 repeat.
        bus.btn_in[BTN_U] = 1'b1;
        tick(6);
        check_all("u_E", 5'b00010, 5'b00010, 5'b00000, 5'b00010);
        for (int k = 1; k <= 46; k++) begin
            tick(1);
            check($sformatf("u_rpt_E+%0d", k), 32'(bus.btn_repeat[BTN_U]),
                  32'((k == 20 || k == 25 || k == 30 || k == 35) ? 1 : 0));
            check($sformatf("u_rel_E+%0d", k), 32'(bus.btn_release[BTN_U]),
                  32'((k == 40) ? 1 : 0));
            check($sformatf("u_lvl_E+%0d", k), 32'(bus.btn_level[BTN_U]),
                  32'((k < 40) ? 1 : 0));
            if (k == 34) bus.btn_in[BTN_U] = 1'b0;
        end

        // Release while still in the initial delay: only the press repeat.
        base = repeat_cnt[BTN_U];
        bus.btn_in[BTN_U] = 1'b1;
        tick(6);
        check("ud_E.repeat", 32'(bus.btn_repeat), 32'h2);
        tick(4);
        bus.btn_in[BTN_U] = 1'b0;
        tick(30);
        check("ud.repeat_count", 32'(repeat_cnt[BTN_U] - base), 32'd1);
        check("ud.level", 32'(bus.btn_level), 32'h0);

        // Simultaneous BTNL + BTND, then reset mid-hold.
        bus.btn_in = 5'b10100;
        tick(6);
        check_all("ld_E", 5'b10100, 5'b10100, 5'b00000, 5'b00000);
        tick(1);
        check_all("ld_E1", 5'b10100, 5'b00000, 5'b00000, 5'b00000);
        tick(3);
        reset = 1'b1;
        tick(1);
        check_all("ld_rst", 5'b00000, 5'b00000, 5'b00000, 5'b00000);
        reset = 1'b0;
        tick(5);
        check_all("ld_re5", 5'b00000, 5'b00000, 5'b00000, 5'b00000);
        tick(1);
        check_all("ld_re6", 5'b10100, 5'b10100, 5'b00000, 5'b00000);
        tick(1);
        check_all("ld_re7", 5'b10100, 5'b00000, 5'b00000, 5'b00000);

        // Unmasked channels must never have produced a repeat pulse.
        check("nomask.repeat",
              32'(repeat_cnt[BTN_C] + repeat_cnt[BTN_L] + repeat_cnt[BTN_R] + repeat_cnt[BTN_D]),
              32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
